// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never narrower than one bit so WIDTH=1 still has a counter.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// 1-bit full adder built from two half adders; the only combinational datapath
// element of the serial adder.
module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module bit_full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (.x(x),  .y(y), .s(s0), .co(c0));
    halfadder u_ha1 (.x(s0), .y(c), .s(s),  .co(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: time-shares one full-adder cell over WIDTH cycles,
// LSB first, with a start/busy/done handshake and held registered result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_adder_ctrl: WIDTH must be within 1..64");
    end

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic             c_reg;
    logic             c_next;
    logic             s_bit;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    bit_full_adder u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .c  (c_reg),
        .s  (s_bit),
        .co (c_next)
    );

    // Sum bits enter at the MSB so after WIDTH shifts the word is aligned.
    always_comb begin
        s_next           = s_sh >> 1;
        s_next[WIDTH-1]  = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            c_reg <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_next;
            c_reg <= c_next;
            cnt   <= last ? cnt : cnt + CNT_W'(1);
        end
    end

    // Result registers only move on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last) begin
            sum  <= s_next;
            cout <= c_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
